// File: rtl/fifo_ctrl_v2_pkg.sv
// Shared FIFO definitions: read-mode constants and the pointer wrap helper.
// Used by the FIFO controller and its storage.
package fifo_defs;

  localparam int FWFT_OFF = 0;
  localparam int FWFT_ON  = 1;

  // Wraps at depth-1 rather than relying on power-of-two rollover.
  function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/fifo_ctrl_v2_mem_dp.sv
// Simple dual-port RAM for the FIFO: synchronous write, asynchronous read.
// Contents are deliberately not reset.
module fifo_mem_dp #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 32,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [WIDTH-1:0]      wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [WIDTH-1:0]      rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_ctrl_v2.sv
// Synchronous FIFO with selectable registered/FWFT read, occupancy count,
// programmable almost-full/almost-empty flags and sticky overflow/underflow.
module fifo_ctrl_v2 #(
  parameter int WIDTH         = 8,
  parameter int DEPTH         = 32,
  parameter int FWFT          = 0,
  parameter int AFULL_THRESH  = DEPTH - 4,
  parameter int AEMPTY_THRESH = 4,
  parameter int POINTER_WIDTH = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         din,
  output logic                     full,
  output logic                     almost_full,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         dout,
  output logic                     dout_valid,
  output logic                     empty,
  output logic                     almost_empty,
  output logic [POINTER_WIDTH:0]   count,
  input  logic                     err_clr,
  output logic                     overflow,
  output logic                     underflow
);
  import fifo_defs::*;

  localparam logic [POINTER_WIDTH:0] CNT_DEPTH = (POINTER_WIDTH + 1)'(DEPTH);
  localparam logic [POINTER_WIDTH:0] CNT_ONE   = 1;

  logic [POINTER_WIDTH-1:0] wr_ptr;
  logic [POINTER_WIDTH-1:0] rd_ptr;
  logic [POINTER_WIDTH:0]   count_q;
  logic [WIDTH-1:0]         rdata;
  logic                     wr_fire;
  logic                     rd_fire;

  // Handshake: wr_en is a request, !full its ready; rd_en is a request,
  // !empty its ready. A transfer happens only when both are high at the edge;
  // there is no same-cycle bypass in either direction.
  assign wr_fire = wr_en && !full;
  assign rd_fire = rd_en && !empty;

  assign count        = count_q;
  assign full         = (count_q == CNT_DEPTH);
  assign empty        = (count_q == '0);
  assign almost_full  = (int'(count_q) >= AFULL_THRESH);
  assign almost_empty = (int'(count_q) <= AEMPTY_THRESH);

  fifo_mem_dp #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH),
    .ADDR_WIDTH(POINTER_WIDTH)
  ) u_mem (
    .clk  (clk),
    .we   (wr_fire),
    .waddr(wr_ptr),
    .wdata(din),
    .raddr(rd_ptr),
    .rdata(rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (wr_fire) wr_ptr <= POINTER_WIDTH'(ptr_inc(32'(wr_ptr), DEPTH));
      if (rd_fire) rd_ptr <= POINTER_WIDTH'(ptr_inc(32'(rd_ptr), DEPTH));
      case ({wr_fire, rd_fire})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

  // A new error event outranks a simultaneous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_en && full)     overflow <= 1'b1;
      else if (err_clr)      overflow <= 1'b0;
      if (rd_en && empty)    underflow <= 1'b1;
      else if (err_clr)      underflow <= 1'b0;
    end
  end

  generate
    if (FWFT == FWFT_OFF) begin : g_std
      logic [WIDTH-1:0] dout_q;
      logic             valid_q;

      // dout keeps its last word when no read fires; only valid drops.
      always_ff @(posedge clk) begin
        if (rst) begin
          dout_q  <= '0;
          valid_q <= 1'b0;
        end else begin
          valid_q <= rd_fire;
          if (rd_fire) dout_q <= rdata;
        end
      end

      assign dout       = dout_q;
      assign dout_valid = valid_q;
    end else begin : g_fwft
      assign dout       = empty ? '0 : rdata;
      assign dout_valid = !empty;
    end
  endgenerate

endmodule

// File: doc/fifo_ctrl_v2.md
Name: fifo_ctrl_v2

Overview:
Parametrised synchronous FIFO, the successor to the basic IO-circuit FIFO. It adds selectable read mode (standard registered read or first-word fall-through), an occupancy count, programmable almost-full/almost-empty flags, and sticky overflow/underflow error flags. Used between UART/IO blocks and the CPU memory-mapped interface, where software polls count and thresholds.

Parameters:
WIDTH, 8, data word width in bits
DEPTH, 32, number of entries; any value >= 2, not required to be a power of two
FWFT, 0, read mode: 0 = standard (data one cycle after rd_en), 1 = first-word fall-through
AFULL_THRESH, DEPTH-4, almost_full asserted when count >= AFULL_THRESH
AEMPTY_THRESH, 4, almost_empty asserted when count <= AEMPTY_THRESH
POINTER_WIDTH, $clog2(DEPTH), read/write pointer width (derived)

Ports:
clk  input  1  system clock; all logic on posedge
rst  input  1  synchronous, active-high reset
wr_en  input  1  write request
din  input  WIDTH  write data
full  output  1  count == DEPTH
almost_full  output  1  count >= AFULL_THRESH
rd_en  input  1  read request (FWFT: acknowledge/pop of presented word)
dout  output  WIDTH  read data
dout_valid  output  1  dout holds a valid word
empty  output  1  count == 0
almost_empty  output  1  count <= AEMPTY_THRESH
count  output  POINTER_WIDTH+1  current occupancy, 0..DEPTH
err_clr  input  1  clears sticky error flags
overflow  output  1  sticky: write attempted while full
underflow  output  1  sticky: read attempted while empty

Behaviour:
- Reset (rst=1 at posedge): wr_ptr, rd_ptr, count = 0; dout = 0; dout_valid = 0; overflow = underflow = 0; empty = 1, almost_empty = 1, full = 0, almost_full = (AFULL_THRESH == 0). Memory contents are not cleared. Reset mid-operation discards all data immediately.
- Write accepted (wr_fire) = wr_en && !full. Read accepted (rd_fire) = rd_en && !empty. There is no bypass: a write to a full FIFO is rejected even if a read fires in the same cycle, and a read from an empty FIFO is rejected even if a write fires.
- wr_fire: mem[wr_ptr] <= din; wr_ptr wraps from DEPTH-1 to 0. rd_fire: rd_ptr wraps the same way.
- count: +1 on wr_fire only, -1 on rd_fire only, unchanged when both or neither fire.
- All flags are combinational from the count register, so they update the cycle after the event.
- FWFT=0: on rd_fire, dout <= mem[rd_ptr] and dout_valid <= 1 next cycle. Without rd_fire, dout_valid <= 0 and dout holds its last value (it is not zeroed). Read latency is 1 cycle.
- FWFT=1: dout = mem[rd_ptr] when !empty, else 0; dout_valid = !empty. rd_fire pops, and the next word appears in the cycle after the pop. A word written into an empty FIFO is visible one cycle after the write edge.
- Errors: overflow sets on wr_en && full; underflow sets on rd_en && empty. Both hold until err_clr or rst. If err_clr and a new error event occur in the same cycle, the set wins.
- Width: count is POINTER_WIDTH+1 bits so it can represent DEPTH. Pointer wrap compares against DEPTH-1, so non-power-of-two depths are exact.

Decomposition:
- Shared include/package fifo_defs: FWFT_OFF = 0 and FWFT_ON = 1 mode constants; a pointer-wrap increment function (ptr == DEPTH-1 ? 0 : ptr+1).
- One sub-module: fifo_mem_dp, a simple dual-port RAM (WIDTH x DEPTH) with synchronous write and asynchronous read. The FWFT=0 output register lives in fifo_ctrl_v2.
- Run every test below for both FWFT=0 and FWFT=1.

Test Plan:
- Fill/drain (DEPTH=8, WIDTH=8): write 0x10..0x17 -> full=1 and count=8 after the 8th edge; almost_full first asserts at count=4 (AFULL_THRESH=4). Read 8 -> data 0x10..0x17 in order, empty=1, count=0.
- Wrap, non-power-of-two (DEPTH=5): 3 passes of write 4 / read 4 -> pointers wrap 4->0, data order preserved, count never exceeds 4.
- Simultaneous at boundaries: at count=8 (full), wr_en=rd_en=1 -> read pops, write is rejected, count=7, overflow=1. At count=3, wr_en=rd_en=1 -> count stays 3 and both words are handled correctly.
- Error flags: rd_en with empty=1 -> underflow=1 and stays set for 10 cycles; err_clr pulse -> 0. err_clr together with rd_en on empty -> underflow stays 1.
- Latency: FWFT=0, write 0xA5 then rd_en -> dout=0xA5 with dout_valid=1 exactly 1 cycle after rd_fire. FWFT=1 -> dout=0xA5 and dout_valid=1 one cycle after the write edge, before any rd_en.
- Reset mid-operation: count=5, rst held 1 cycle -> count=0, empty=1, dout_valid=0, flags cleared. The next write/read returns only post-reset data.
